// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared sizes and state encodings for the voice allocator
package synth_pkg;

    localparam int NUM_VOICES = 4;
    localparam int KEY_W      = 5;
    localparam int AGE_W      = 3;

    typedef enum logic [1:0] {
        V_FREE      = 2'd0,
        V_HELD      = 2'd1,
        V_RELEASING = 2'd2
    } voice_state_e;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_STEAL_KILL = 2'd1,
        S_STEAL_GATE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/voice_select.sv
// rtl/voice_select.sv - combinational first-free, oldest-victim and key-match search
module voice_select #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int KEY_W      = synth_pkg::KEY_W,
    parameter int AGE_W      = synth_pkg::AGE_W,
    localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic [NUM_VOICES-1:0]       free_mask,
    input  logic [NUM_VOICES-1:0]       held_mask,
    input  logic [NUM_VOICES-1:0]       rel_mask,
    input  logic [NUM_VOICES*AGE_W-1:0] ages,
    input  logic [NUM_VOICES*KEY_W-1:0] keys,
    input  logic [KEY_W-1:0]            key_code,
    output logic                        free_hit,
    output logic [IDX_W-1:0]            free_idx,
    output logic [IDX_W-1:0]            victim_idx,
    output logic                        match_hit,
    output logic [IDX_W-1:0]            match_idx,
    output logic                        held_hit,
    output logic [IDX_W-1:0]            held_idx
);

    logic             rel_found;
    logic [IDX_W-1:0] rel_idx;
    logic [AGE_W-1:0] rel_age;
    logic             hld_found;
    logic [IDX_W-1:0] hld_idx;
    logic [AGE_W-1:0] hld_age;

    always_comb begin
        free_hit  = 1'b0;
        free_idx  = '0;
        match_hit = 1'b0;
        match_idx = '0;
        held_hit  = 1'b0;
        held_idx  = '0;
        rel_found = 1'b0;
        rel_idx   = '0;
        rel_age   = '0;
        hld_found = 1'b0;
        hld_idx   = '0;
        hld_age   = '0;
        // Ascending scan with strict '>' so age ties resolve to the lowest index
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (free_mask[i] && !free_hit) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            if ((held_mask[i] || rel_mask[i]) && keys[i*KEY_W +: KEY_W] == key_code && !match_hit) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (held_mask[i] && keys[i*KEY_W +: KEY_W] == key_code && !held_hit) begin
                held_hit = 1'b1;
                held_idx = IDX_W'(i);
            end
            if (rel_mask[i] && (!rel_found || ages[i*AGE_W +: AGE_W] > rel_age)) begin
                rel_found = 1'b1;
                rel_idx   = IDX_W'(i);
                rel_age   = ages[i*AGE_W +: AGE_W];
            end
            if (held_mask[i] && (!hld_found || ages[i*AGE_W +: AGE_W] > hld_age)) begin
                hld_found = 1'b1;
                hld_idx   = IDX_W'(i);
                hld_age   = ages[i*AGE_W +: AGE_W];
            end
        end
        victim_idx = rel_found ? rel_idx : hld_idx;
    end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - assigns key events to ADSR voice slots with oldest-voice stealing
module voice_allocator #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int KEY_W      = synth_pkg::KEY_W,
    parameter int AGE_W      = synth_pkg::AGE_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  key_valid,
    input  logic                                  key_down,
    input  logic [KEY_W-1:0]                      key_code,
    output logic                                  key_ready,
    input  logic [NUM_VOICES-1:0]                 voice_release_done,
    output logic [NUM_VOICES-1:0]                 voice_gate,
    output logic [NUM_VOICES-1:0]                 voice_restart,
    output logic [NUM_VOICES*KEY_W-1:0]           voice_key,
    output logic                                  steal_event,
    output logic [$clog2(NUM_VOICES+1)-1:0]       active_count
);

    import synth_pkg::*;

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = $clog2(NUM_VOICES+1);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    voice_state_e            vstate   [NUM_VOICES];
    logic [KEY_W-1:0]        vkey     [NUM_VOICES];
    logic [AGE_W-1:0]        vage     [NUM_VOICES];
    ctrl_state_e             state;
    logic [IDX_W-1:0]        victim;
    logic [KEY_W-1:0]        pend_key;

    voice_state_e            st_n     [NUM_VOICES];
    logic [KEY_W-1:0]        key_n    [NUM_VOICES];
    logic [AGE_W-1:0]        age_n    [NUM_VOICES];
    ctrl_state_e             state_n;
    logic [IDX_W-1:0]        victim_n;
    logic [KEY_W-1:0]        pend_key_n;
    logic [NUM_VOICES-1:0]   gate_n;
    logic [NUM_VOICES-1:0]   restart_n;
    logic                    steal_n;
    logic [CNT_W-1:0]        count_n;

    logic [NUM_VOICES-1:0]       freeing;
    logic [NUM_VOICES-1:0]       free_mask;
    logic [NUM_VOICES-1:0]       held_mask;
    logic [NUM_VOICES-1:0]       rel_mask;
    logic [NUM_VOICES*AGE_W-1:0] ages_flat;
    logic [NUM_VOICES*KEY_W-1:0] keys_flat;

    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim_idx;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             held_hit;
    logic [IDX_W-1:0] held_idx;

    logic             alloc;
    logic             steal_start;
    logic [IDX_W-1:0] tgt;

    assign key_ready = (state == S_IDLE);
    assign voice_key = keys_flat;

    // A finishing envelope frees its voice in time for this cycle's allocation,
    // except the voice currently being stolen.
    always_comb begin
        freeing   = '0;
        free_mask = '0;
        held_mask = '0;
        rel_mask  = '0;
        ages_flat = '0;
        keys_flat = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            freeing[i]   = (vstate[i] == V_RELEASING) && voice_release_done[i] &&
                           !((state != S_IDLE) && (victim == IDX_W'(i)));
            free_mask[i] = (vstate[i] == V_FREE) || freeing[i];
            held_mask[i] = (vstate[i] == V_HELD);
            rel_mask[i]  = (vstate[i] == V_RELEASING) && !freeing[i];
            ages_flat[i*AGE_W +: AGE_W] = vage[i];
            keys_flat[i*KEY_W +: KEY_W] = vkey[i];
        end
    end

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .KEY_W      (KEY_W),
        .AGE_W      (AGE_W)
    ) u_select (
        .free_mask  (free_mask),
        .held_mask  (held_mask),
        .rel_mask   (rel_mask),
        .ages       (ages_flat),
        .keys       (keys_flat),
        .key_code   (key_code),
        .free_hit   (free_hit),
        .free_idx   (free_idx),
        .victim_idx (victim_idx),
        .match_hit  (match_hit),
        .match_idx  (match_idx),
        .held_hit   (held_hit),
        .held_idx   (held_idx)
    );

    always_comb begin
        st_n       = vstate;
        key_n      = vkey;
        age_n      = vage;
        state_n    = state;
        victim_n   = victim;
        pend_key_n = pend_key;
        gate_n     = voice_gate;
        restart_n  = '0;
        steal_n    = 1'b0;
        alloc      = 1'b0;
        steal_start = 1'b0;
        tgt        = free_idx;

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (freeing[i]) begin
                st_n[i]  = V_FREE;
                age_n[i] = '0;
            end
        end

        if (state == S_IDLE && key_valid && key_down) begin
            alloc = 1'b1;
            if (match_hit) begin
                tgt         = match_idx;
                steal_start = 1'b1;
            end else if (free_hit) begin
                tgt = free_idx;
            end else begin
                tgt         = victim_idx;
                steal_start = 1'b1;
            end
        end

        if (alloc) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) != tgt && st_n[i] != V_FREE && age_n[i] != AGE_MAX)
                    age_n[i] = age_n[i] + 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (alloc && steal_start) begin
                    state_n        = S_STEAL_KILL;
                    victim_n       = tgt;
                    pend_key_n     = key_code;
                    gate_n[tgt]    = 1'b0;
                    restart_n[tgt] = 1'b1;
                    steal_n        = 1'b1;
                end else if (alloc) begin
                    st_n[tgt]   = V_HELD;
                    key_n[tgt]  = key_code;
                    age_n[tgt]  = '0;
                    gate_n[tgt] = 1'b1;
                end else if (key_valid && !key_down && held_hit) begin
                    st_n[held_idx]   = V_RELEASING;
                    gate_n[held_idx] = 1'b0;
                end
            end
            S_STEAL_KILL: begin
                state_n       = S_STEAL_GATE;
                st_n[victim]  = V_HELD;
                key_n[victim] = pend_key;
                age_n[victim] = '0;
            end
            S_STEAL_GATE: begin
                state_n        = S_IDLE;
                gate_n[victim] = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        count_n = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            count_n = count_n + CNT_W'(st_n[i] != V_FREE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate[i] <= V_FREE;
                vkey[i]   <= '0;
                vage[i]   <= '0;
            end
            state         <= S_IDLE;
            victim        <= '0;
            pend_key      <= '0;
            voice_gate    <= '0;
            voice_restart <= '0;
            steal_event   <= 1'b0;
            active_count  <= '0;
        end else begin
            vstate        <= st_n;
            vkey          <= key_n;
            vage          <= age_n;
            state         <= state_n;
            victim        <= victim_n;
            pend_key      <= pend_key_n;
            voice_gate    <= gate_n;
            voice_restart <= restart_n;
            steal_event   <= steal_n;
            active_count  <= count_n;
        end
    end

endmodule
